// File: rtl/micro_seq_pkg.sv
// rtl/micro_seq_pkg.sv - shared op encodings, field positions and state encoding for micro_sequencer
package micro_seq_pkg;

  // microword field positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int SEL_MSB = 12;
  localparam int SEL_LSB = 10;
  localparam int TGT_MSB = 7;
  localparam int TGT_LSB = 0;

  localparam int DEFAULT_STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    OP_NEXT     = 3'b000,
    OP_JUMP     = 3'b001,
    OP_BRT      = 3'b010,
    OP_BRF      = 3'b011,
    OP_CALL     = 3'b100,
    OP_RET      = 3'b101,
    OP_DISPATCH = 3'b110,
    OP_HALT     = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  function automatic op_t get_op(input logic [15:0] word);
    return op_t'(word[OP_MSB:OP_LSB]);
  endfunction

endpackage

// File: rtl/micro_stack.sv
// rtl/micro_stack.sv - parameterised LIFO holding micro-sequencer return addresses
module micro_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] SP_FULL = DEPTH[AW:0];
  localparam logic [AW:0] SP_ONE  = 1;

  // sp counts valid entries, so it needs one bit more than the index
  logic [AW:0]      sp;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    top_idx;

  assign full    = (sp == SP_FULL);
  assign empty   = (sp == '0);
  assign top_idx = sp[AW-1:0] - AW'(1);
  assign top     = mem[top_idx];

  // entry count; a push into a full stack or pop from an empty one is ignored
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_ONE;
    end else if (pop && !empty) begin
      sp <= sp - SP_ONE;
    end
  end

  // storage needs no reset: entries are only read below the stack pointer
  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem[sp[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - microprogram sequencer feeding the microcode ROM address; MICRO_SEQUENCER_STACK_EN enables CALL/RET stack
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [15:0] q,
  input  logic [7:0]  cond,
  input  logic [7:0]  dispatch_addr,
  input  logic        stall,
  output logic [7:0]  address,
  output logic        running,
  output logic        halted,
  output logic        stack_err
);

  state_t     state;
  logic [7:0] pc;
  logic [7:0] pc_inc;
  logic [7:0] tgt;
  logic [2:0] sel;
  op_t        op;
  logic       halt_now;
  logic       unused_bits;

  assign pc_inc = pc + 8'd1;
  assign tgt    = q[TGT_MSB:TGT_LSB];
  assign sel    = q[SEL_MSB:SEL_LSB];
  assign op     = get_op(q);

`ifdef MICRO_SEQUENCER_STACK_EN
  logic       push;
  logic       pop;
  logic       err_set;
  logic       stack_err_q;
  logic [7:0] stack_top;
  logic       stack_full;
  logic       stack_empty;

  // return address pushed by CALL is the word after the call site
  micro_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (8)
  ) u_stack (
    .clock (clock),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (stack_top),
    .full  (stack_full),
    .empty (stack_empty)
  );

  assign stack_err   = stack_err_q;
  assign unused_bits = ^q[9:8];
`else
  assign stack_err   = 1'b0;
  assign unused_bits = ^{q[9:8], STACK_DEPTH[0]};
`endif

  // next-address decode: the ROM registers this at every edge, so no bubbles
  always_comb begin
    address  = pc;
    halt_now = 1'b0;
`ifdef MICRO_SEQUENCER_STACK_EN
    push     = 1'b0;
    pop      = 1'b0;
    err_set  = 1'b0;
`endif
    case (state)
      ST_PRIME: address = 8'h00;
      ST_RUN: begin
        if (!stall) begin
          case (op)
            OP_NEXT: address = pc_inc;
            OP_JUMP: address = tgt;
            OP_BRT:  address = cond[sel] ? tgt : pc_inc;
            OP_BRF:  address = cond[sel] ? pc_inc : tgt;
`ifdef MICRO_SEQUENCER_STACK_EN
            OP_CALL: begin
              // overflow still takes the jump; only the return address is lost
              address = tgt;
              push    = !stack_full;
              err_set = stack_full;
            end
            OP_RET: begin
              if (stack_empty) begin
                address = 8'h00;
                err_set = 1'b1;
              end else begin
                address = stack_top;
                pop     = 1'b1;
              end
            end
`else
            OP_CALL: address = tgt;
            OP_RET:  address = pc_inc;
`endif
            OP_DISPATCH: address = dispatch_addr;
            OP_HALT: begin
              address  = pc;
              halt_now = 1'b1;
            end
            default: address = pc_inc;
          endcase
        end
      end
      default: address = pc;
    endcase
  end

  // control FSM with registered status outputs; pc tracks what the ROM sampled
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_PRIME;
      pc          <= 8'h00;
      running     <= 1'b0;
      halted      <= 1'b0;
`ifdef MICRO_SEQUENCER_STACK_EN
      stack_err_q <= 1'b0;
`endif
    end else begin
      pc <= address;
`ifdef MICRO_SEQUENCER_STACK_EN
      stack_err_q <= stack_err_q | err_set;
`endif
      case (state)
        ST_PRIME: begin
          state   <= ST_RUN;
          running <= 1'b1;
        end
        ST_RUN: begin
          if (halt_now) begin
            state   <= ST_HALT;
            running <= 1'b0;
            halted  <= 1'b1;
          end
        end
        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

endmodule
